// File: rtl/softmax_argmax_pkg.sv
// softmax_argmax_pkg: shared round-state type and index-width helper for the arg-max cell
package softmax_argmax_pkg;
  typedef enum logic {ROUND_IDLE, ROUND_OPEN} round_e;
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/softmax_argmax_if.sv
// softmax_argmax_if: score stream in, registered {valid, arg-max index} out
interface softmax_argmax_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] input_index;
  logic [DATA_WIDTH-1:0] input_value;
  logic                  input_enable;
  logic [DATA_WIDTH:0]   output_result;
  modport master (output input_index, output input_value, output input_enable, input output_result);
  modport slave (input input_index, input input_value, input input_enable, output output_result);
endinterface

// File: rtl/softmax_argmax_cell_select.sv
// softmax_argmax_cell_select: next running max/arg; strict compare keeps the lower index on ties
module softmax_argmax_cell_select #(
  parameter int DATA_WIDTH = 32,
  parameter int AW = 1
) (
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [AW-1:0]         index,
  input  logic [DATA_WIDTH-1:0] max_q,
  input  logic [AW-1:0]         arg_q,
  output logic [DATA_WIDTH-1:0] max_d,
  output logic [AW-1:0]         arg_d
);
  logic take;
  always_comb begin
    take = start || (value > max_q);
    max_d = take ? value : max_q;
    arg_d = start ? '0 : take ? index : arg_q;
  end
endmodule

// File: rtl/softmax_argmax_cell.sv
// softmax_argmax_cell: streaming arg-max over WEIGHT_AMOUNT scores with a one-cycle result pulse
module softmax_argmax_cell
  import softmax_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WEIGHT_AMOUNT = 2
) (
  input logic             clk,
  input logic             rst,
  softmax_argmax_if.slave bus
);
  localparam int AW = index_width(WEIGHT_AMOUNT);
  localparam logic [DATA_WIDTH-1:0] LAST = DATA_WIDTH'(WEIGHT_AMOUNT - 1);
  round_e state, state_n;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [AW-1:0] arg_q, arg_d;
  logic [DATA_WIDTH:0] result_n;
  logic hit, first, accept, done;
  softmax_argmax_cell_select #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_select (
    .start (first),
    .value (bus.input_value),
    .index (AW'(bus.input_index)),
    .max_q (max_q),
    .arg_q (arg_q),
    .max_d (max_d),
    .arg_d (arg_d)
  );
  // a round only completes if it was opened by index 0 since the last reset/completion
  always_comb begin
    hit = bus.input_enable && (bus.input_index <= LAST);
    first = hit && (bus.input_index == '0);
    accept = first || (hit && state == ROUND_OPEN);
    done = accept && (bus.input_index == LAST);
    state_n = done ? ROUND_IDLE : first ? ROUND_OPEN : state;
    result_n = done ? {1'b1, DATA_WIDTH'(arg_d)} : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ROUND_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      arg_q <= '0;
      bus.output_result <= '0;
    end else begin
      if (accept) begin
        max_q <= max_d;
        arg_q <= arg_d;
      end
      bus.output_result <= result_n;
    end
  end
endmodule

// File: tb/tb_softmax_argmax_cell.sv
// tb_softmax_argmax_cell: directed literal checks plus random stream against a round-buffer model
module tb_softmax_argmax_cell;
  localparam int DW = 32;
  localparam int W = 2;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  softmax_argmax_if #(.DATA_WIDTH(DW)) bus();
  softmax_argmax_cell #(.DATA_WIDTH(DW), .WEIGHT_AMOUNT(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: buffer the scores of an open round, pick the first maximum when the last index arrives
  int ri[$];
  logic [DW-1:0] rv[$];
  bit open = 0;
  always begin
    logic [DW:0] exp;
    logic r, e;
    logic [DW-1:0] i, v;
    int best;
    @(posedge clk);
    r = rst; e = bus.input_enable; i = bus.input_index; v = bus.input_value;
    exp = '0;
    if (r) begin
      open = 0; ri.delete(); rv.delete();
    end else if (e && i < W) begin
      if (i == 0) begin
        open = 1; ri.delete(); rv.delete();
      end
      if (open) begin
        ri.push_back(int'(i));
        rv.push_back(v);
        if (i == W - 1) begin
          best = 0;
          for (int k = 1; k < rv.size(); k++) if (rv[k] > rv[best]) best = k;
          exp = {1'b1, DW'(ri[best])};
          open = 0; ri.delete(); rv.delete();
        end
      end
    end
    #1 chk("model", bus.output_result, exp);
  end
  task automatic drive(input int idx, input logic [DW-1:0] val, input logic en);
    @(negedge clk);
    bus.input_index = DW'(idx);
    bus.input_value = val;
    bus.input_enable = en;
  endtask
  task automatic lit(input string name, input logic [DW:0] exp);
    @(posedge clk);
    #2 chk(name, bus.output_result, exp);
  endtask
  initial begin
    bus.input_index = '0;
    bus.input_value = '0;
    bus.input_enable = 0;
    lit("reset", '0);
    lit("reset_hold", '0);
    @(negedge clk) rst = 0;
    for (int n = 0; n < 6; n++) begin
      drive(int'($urandom_range(0, 3)), $urandom, 0);
      lit("idle", '0);
    end
    drive(0, 2, 1); drive(1, 1, 1);
    lit("first_wins", 33'h1_0000_0000);
    drive(0, 0, 0);
    lit("pulse_one_cycle", '0);
    drive(0, 3, 1); drive(1, 6, 0);
    lit("incomplete", '0);
    drive(0, 1, 1); drive(1, 9, 1);
    lit("second_wins", 33'h1_0000_0001);
    drive(0, 5, 1); drive(1, 5, 1);
    lit("tie_low_index", 33'h1_0000_0000);
    drive(0, 4, 1); drive(1, 7, 1);
    lit("b2b_first", 33'h1_0000_0001);
    drive(0, 8, 1);
    lit("b2b_gap", '0);
    drive(1, 2, 1);
    lit("b2b_second", 33'h1_0000_0000);
    drive(0, 1, 1); drive(1, 9, 1);
    lit("pre_reset_pulse", 33'h1_0000_0001);
    @(negedge clk);
    rst = 1;
    bus.input_enable = 0;
    #1 chk("reset_immediate", bus.output_result, '0);
    @(negedge clk) rst = 0;
    drive(0, 3, 1);
    @(negedge clk);
    rst = 1;
    bus.input_enable = 0;
    @(negedge clk) rst = 0;
    drive(1, 6, 1);
    lit("idx1_after_reset", '0);
    drive(0, 0, 0);
    lit("idx1_after_reset_next", '0);
    drive(2, 50, 1);
    lit("out_of_range", '0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      bus.input_enable = ($urandom_range(0, 3) != 0);
      bus.input_index = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 3)) : DW'(n % W);
      bus.input_value = $urandom_range(0, 1) ? DW'($urandom_range(0, 7)) : DW'($urandom);
    end
    @(negedge clk);
    rst = 0;
    bus.input_enable = 0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
